// File: rtl/fc_pkg.sv
// Shared Fibre Channel definitions: port states, primitive sequence classes,
// primitive ordered-set encodings and the ordered-set classifier.
package fc;

    typedef enum logic [3:0] {
        STATE_AC  = 4'd0,
        STATE_LR1 = 4'd1,
        STATE_LR2 = 4'd2,
        STATE_LR3 = 4'd3,
        STATE_OL1 = 4'd4,
        STATE_OL2 = 4'd5,
        STATE_OL3 = 4'd6,
        STATE_LF1 = 4'd7,
        STATE_LF2 = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        SEQ_NONE = 3'd0,
        SEQ_IDLE = 3'd1,
        SEQ_LR   = 3'd2,
        SEQ_LRR  = 3'd3,
        SEQ_OLS  = 3'd4,
        SEQ_NOS  = 3'd5
    } seq_t;

    // Ordered sets: K28.5 followed by three data characters, byte 3 first.
    localparam logic [31:0] IDLE = 32'hBC95_B5B5;  // K28.5 D21.4 D21.5 D21.5
    localparam logic [31:0] LR   = 32'hBC49_BF49;  // K28.5 D9.2  D31.5 D9.2
    localparam logic [31:0] LRR  = 32'hBC35_BF49;  // K28.5 D21.1 D31.5 D9.2
    localparam logic [31:0] OLS  = 32'hBC35_8A55;  // K28.5 D21.1 D10.4 D21.2
    localparam logic [31:0] NOS  = 32'hBC55_BF45;  // K28.5 D21.2 D31.5 D5.2
    localparam logic [3:0]  OS_DATAK = 4'b1000;

    // Map one received word to its primitive sequence class.
    function automatic seq_t classify(input logic [31:0] data, input logic [3:0] datak);
        seq_t c;
        c = SEQ_NONE;
        if (datak == OS_DATAK) begin
            case (data)
                IDLE:    c = SEQ_IDLE;
                LR:      c = SEQ_LR;
                LRR:     c = SEQ_LRR;
                OLS:     c = SEQ_OLS;
                NOS:     c = SEQ_NOS;
                default: c = SEQ_NONE;
            endcase
        end else begin
            c = SEQ_NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/fc_seq_detect.sv
// Primitive sequence recognizer: classifies each valid word and counts runs
// of identical ordered sets, emitting one registered event per run.
module fc_seq_detect
    import fc::*;
#(
    parameter int SEQ_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_datak,
    input  logic        rx_valid,
    input  logic        rx_sync,
    output seq_t        evt,
    output logic        evt_valid
);

    localparam int CW = $clog2(SEQ_COUNT + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(SEQ_COUNT);

    seq_t          cls_s;
    seq_t          last_r;
    seq_t          evt_r;
    logic          evt_valid_r;
    logic          same_s;
    logic          fire_s;
    logic [CW-1:0] run_r;
    logic [CW-1:0] run_next_s;

    // Next run length and single-shot event decision for the current word.
    always_comb begin
        cls_s      = classify(rx_data, rx_datak);
        same_s     = (cls_s == last_r) && (run_r != {CW{1'b0}});
        run_next_s = {CW{1'b0}};
        if (cls_s == SEQ_NONE) begin
            run_next_s = {CW{1'b0}};
        end else if (same_s) begin
            run_next_s = (run_r == RUN_MAX) ? run_r : run_r + CW'(1);
        end else begin
            run_next_s = CW'(1);
        end
        // A saturated run that continues must not fire again.
        fire_s = (cls_s != SEQ_NONE) && (run_next_s == RUN_MAX) &&
                 !(same_s && (run_r == RUN_MAX));
    end

    // Run counter and event register; loss of sync discards any partial run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_r       <= {CW{1'b0}};
            last_r      <= SEQ_NONE;
            evt_r       <= SEQ_NONE;
            evt_valid_r <= 1'b0;
        end else if (!rx_sync) begin
            run_r       <= {CW{1'b0}};
            last_r      <= SEQ_NONE;
            evt_r       <= SEQ_NONE;
            evt_valid_r <= 1'b0;
        end else if (rx_valid) begin
            run_r       <= run_next_s;
            last_r      <= cls_s;
            evt_r       <= fire_s ? cls_s : SEQ_NONE;
            evt_valid_r <= fire_s;
        end else begin
            evt_r       <= SEQ_NONE;
            evt_valid_r <= 1'b0;
        end
    end

    assign evt       = evt_r;
    assign evt_valid = evt_valid_r;

endmodule

// File: rtl/fc_state_rx.sv
// Fibre Channel port state machine: link initialization, recovery, offline
// handling and R_T_TOV timeout, driven by recognized primitive sequences.
module fc_state_rx
    import fc::*;
#(
    parameter int TIMEOUT_CYCLES = 21250000,
    parameter int SEQ_COUNT      = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_datak,
    input  logic        rx_valid,
    input  logic        rx_sync,
    input  logic        link_reset_req,
    input  logic        offline_req,
    output state_t      state,
    output logic        state_changed,
    output logic        link_up
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_t          evt_s;
    logic          evt_valid_s;
    state_t        state_r;
    state_t        next_s;
    state_t        evt_next_s;
    logic          state_changed_r;
    logic          link_up_r;
    logic          timed_s;
    logic          tmo_s;
    logic [TW-1:0] tmo_cnt_r;
    logic [TW-1:0] tmo_next_s;

    fc_seq_detect #(
        .SEQ_COUNT (SEQ_COUNT)
    ) u_detect (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_datak  (rx_datak),
        .rx_valid  (rx_valid),
        .rx_sync   (rx_sync),
        .evt       (evt_s),
        .evt_valid (evt_valid_s)
    );

    // Destination state for a recognized sequence; unlisted pairs hold.
    function automatic state_t seq_next(input state_t cur, input seq_t ev);
        state_t n;
        n = cur;
        case (cur)
            STATE_AC: case (ev)
                SEQ_LR: n = STATE_LR2; SEQ_LRR: n = STATE_LR3;
                SEQ_OLS: n = STATE_OL2; SEQ_NOS: n = STATE_LF1;
                default: n = cur;
            endcase
            STATE_LR1: case (ev)
                SEQ_LR: n = STATE_LR2; SEQ_LRR: n = STATE_LR3;
                SEQ_NOS: n = STATE_LF1; SEQ_OLS: n = STATE_OL2;
                default: n = cur;
            endcase
            STATE_LR2: case (ev)
                SEQ_LRR: n = STATE_LR3; SEQ_IDLE: n = STATE_AC;
                SEQ_NOS: n = STATE_LF1; SEQ_OLS: n = STATE_OL2;
                default: n = cur;
            endcase
            STATE_LR3: case (ev)
                SEQ_IDLE: n = STATE_AC; SEQ_LR: n = STATE_LR2;
                SEQ_NOS: n = STATE_LF1; SEQ_OLS: n = STATE_OL2;
                default: n = cur;
            endcase
            STATE_OL1: case (ev)
                SEQ_OLS: n = STATE_OL2; SEQ_LR: n = STATE_LR2;
                SEQ_NOS: n = STATE_OL3;
                default: n = cur;
            endcase
            STATE_OL2: case (ev)
                SEQ_LR: n = STATE_LR2; SEQ_LRR: n = STATE_LR3;
                SEQ_NOS: n = STATE_LF1;
                default: n = cur;
            endcase
            STATE_OL3, STATE_LF1: case (ev)
                SEQ_OLS: n = STATE_OL2; SEQ_LR: n = STATE_LR2;
                default: n = cur;
            endcase
            STATE_LF2: case (ev)
                SEQ_NOS: n = STATE_LF1; SEQ_OLS: n = STATE_OL2;
                SEQ_LR: n = STATE_LR2;
                default: n = cur;
            endcase
            default: n = cur;
        endcase
        return n;
    endfunction

    // Prioritized next-state selection and timeout counter update.
    always_comb begin
        timed_s    = (state_r == STATE_LR1) || (state_r == STATE_LR2) ||
                     (state_r == STATE_LR3) || (state_r == STATE_OL2);
        tmo_s      = timed_s && (tmo_cnt_r == TMO_LAST);
        evt_next_s = seq_next(state_r, evt_s);
        next_s     = state_r;
        if (!rx_sync) begin
            next_s = STATE_LF2;
        end else if (offline_req && (state_r != STATE_LF2)) begin
            next_s = STATE_OL1;
        end else if (evt_valid_s && (evt_next_s != state_r)) begin
            next_s = evt_next_s;
        end else if (tmo_s) begin
            next_s = STATE_LF2;
        end else if (link_reset_req && (state_r == STATE_AC)) begin
            next_s = STATE_LR1;
        end else begin
            next_s = state_r;
        end

        if (next_s != state_r) begin
            tmo_next_s = {TW{1'b0}};
        end else if (timed_s) begin
            tmo_next_s = tmo_cnt_r + TW'(1);
        end else begin
            tmo_next_s = {TW{1'b0}};
        end
    end

    // State, timeout counter and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= STATE_OL1;
            tmo_cnt_r       <= {TW{1'b0}};
            state_changed_r <= 1'b0;
            link_up_r       <= 1'b0;
        end else begin
            state_r         <= next_s;
            tmo_cnt_r       <= tmo_next_s;
            state_changed_r <= (next_s != state_r);
            link_up_r       <= (next_s == STATE_AC);
        end
    end

    assign state         = state_r;
    assign state_changed = state_changed_r;
    assign link_up       = link_up_r;

endmodule

// File: tb/tb_fc_state_rx.sv
// Directed bench for fc_state_rx: walks the port through initialization,
// run recognition, timeout, loss of sync, offline and mid-run reset.
module tb_fc_state_rx;
    import fc::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] rx_data;
    logic [3:0]  rx_datak;
    logic        rx_valid;
    logic        rx_sync;
    logic        link_reset_req;
    logic        offline_req;
    state_t      state;
    logic        state_changed;
    logic        link_up;

    int total = 0;
    int fails = 0;
    int chg_cnt = 0;
    int chg_base;

    fc_state_rx #(
        .TIMEOUT_CYCLES (16),
        .SEQ_COUNT      (3)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_data        (rx_data),
        .rx_datak       (rx_datak),
        .rx_valid       (rx_valid),
        .rx_sync        (rx_sync),
        .link_reset_req (link_reset_req),
        .offline_req    (offline_req),
        .state          (state),
        .state_changed  (state_changed),
        .link_up        (link_up)
    );

    always #5 clk = ~clk;

    // Count state_changed pulses shortly after each active edge.
    always @(posedge clk) begin
        #1;
        if (state_changed === 1'b1) chg_cnt = chg_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [3:0] k);
        rx_data  = w;
        rx_datak = k;
        rx_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_os(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) send(w, 4'b1000);
    endtask

    task automatic tick();
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input state_t exp);
        check(tag, 32'(state), 32'(exp));
    endtask

    initial begin
        reset_n = 1'b0; rx_data = 32'h0; rx_datak = 4'h0; rx_valid = 1'b0;
        rx_sync = 1'b1; link_reset_req = 1'b0; offline_req = 1'b0;
        @(negedge clk); @(negedge clk);
        check_state("rst_state", STATE_OL1);
        check("rst_changed", 32'(state_changed), 32'h0);
        check("rst_link_up", 32'(link_up), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // OL1 -> OL2 via OLS; event registered first, state one edge later
        send_os(OLS, 3);
        check_state("ols_not_yet", STATE_OL1);
        tick();
        check_state("ol1_to_ol2", STATE_OL2);
        check("ol2_changed", 32'(state_changed), 32'h1);
        send_os(LR, 3);
        check("ol2_one_pulse", 32'(chg_cnt), 32'd1);
        tick();
        check_state("ol2_to_lr2", STATE_LR2);
        send_os(LRR, 3); tick();
        check_state("lr2_to_lr3", STATE_LR3);
        check("lr3_link_down", 32'(link_up), 32'h0);
        send_os(IDLE, 3); tick();
        check_state("lr3_to_ac", STATE_AC);
        check("ac_link_up", 32'(link_up), 32'h1);

        // Broken LR run must not fire; third consecutive LR does
        chg_base = chg_cnt;
        send_os(LR, 2);
        send(32'h1234_5678, 4'b0000);
        send_os(LR, 2);
        tick();
        check_state("broken_run", STATE_AC);
        check("broken_run_chg", 32'(chg_cnt - chg_base), 32'd0);
        send_os(LR, 1); tick();
        check_state("ac_to_lr2", STATE_LR2);
        check("ac_lr2_down", 32'(link_up), 32'h0);
        chg_base = chg_cnt;
        send_os(LR, 10);
        check("no_refire", 32'(chg_cnt - chg_base), 32'd0);
        check_state("lr2_hold", STATE_LR2);
        send_os(IDLE, 3); tick();
        check_state("lr2_to_ac", STATE_AC);

        // link_reset_req -> LR1, then timeout after exactly 16 cycles
        link_reset_req = 1'b1; tick(); link_reset_req = 1'b0;
        check_state("ac_to_lr1", STATE_LR1);
        for (int i = 0; i < 15; i++) tick();
        check_state("lr1_pre_tmo", STATE_LR1);
        tick();
        check_state("lr1_tmo_lf2", STATE_LF2);
        link_reset_req = 1'b1; tick(); link_reset_req = 1'b0;
        tick();
        check_state("req_dropped", STATE_LF2);

        // Back to AC, then LOS beats a NOS event and link_reset_req
        send_os(LR, 3); tick();
        check_state("lf2_to_lr2", STATE_LR2);
        send_os(IDLE, 3); tick();
        check_state("lr2_to_ac_2", STATE_AC);
        send_os(NOS, 3);
        rx_sync = 1'b0; link_reset_req = 1'b1; tick(); link_reset_req = 1'b0;
        check_state("los_wins", STATE_LF2);
        tick(); tick();
        check_state("los_hold", STATE_LF2);
        rx_sync = 1'b1;
        send_os(NOS, 3); tick();
        check_state("lf2_to_lf1", STATE_LF1);

        // Offline request overrides; events ignored while held
        offline_req = 1'b1; tick();
        check_state("offline_ol1", STATE_OL1);
        chg_base = chg_cnt;
        send_os(OLS, 3); tick();
        check_state("offline_hold", STATE_OL1);
        check("offline_chg", 32'(chg_cnt - chg_base), 32'd0);
        offline_req = 1'b0;
        send(32'h0, 4'b0000);
        send_os(OLS, 3); tick();
        check_state("ol1_to_ol2_b", STATE_OL2);

        // Reset mid-run discards a partial LR run
        send_os(LR, 2);
        #2 reset_n = 1'b0;
        #1;
        check_state("midrun_rst", STATE_OL1);
        check("midrun_changed", 32'(state_changed), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        chg_base = chg_cnt;
        send_os(LR, 1); tick(); tick();
        check_state("partial_gone", STATE_OL1);
        check("partial_chg", 32'(chg_cnt - chg_base), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
